// File: rtl/regfile_param_if.sv
// ----------------------------------------------------------------------------
// regfile_param_if
// Bundles the register-file access signals: the write port (full-word or
// single-lane), two read ports with immediate/move overrides, the mem_data
// selector, the target register tap and the branch-condition request/result.
//   master : drives writes, read indices, mode bits and condition requests
//   slave  : the register file; returns read data, mem_data, target, taken
// ----------------------------------------------------------------------------
interface regfile_param_if #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
);
  localparam int NLANES     = DATA_W / LANE_W;
  localparam int LANE_IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  logic                  wr_en;
  logic [3:0]            wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_lane_mode;
  logic [LANE_IDX_W-1:0] wr_lane;
  logic [3:0]            rd_addr0;
  logic [3:0]            rd_addr1;
  logic [DATA_W-1:0]     rd_data0;
  logic [DATA_W-1:0]     rd_data1;
  logic                  imm;
  logic                  move;
  logic [1:0]            mem_sel;
  logic [DATA_W-1:0]     mem_data;
  logic [DATA_W-1:0]     target;
  logic                  cond_valid;
  logic [3:0]            cond_op;
  logic                  taken;
  logic                  taken_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_lane_mode, wr_lane,
    output rd_addr0, rd_addr1, imm, move, mem_sel, cond_valid, cond_op,
    input  rd_data0, rd_data1, mem_data, target, taken, taken_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_lane_mode, wr_lane,
    input  rd_addr0, rd_addr1, imm, move, mem_sel, cond_valid, cond_op,
    output rd_data0, rd_data1, mem_data, target, taken, taken_valid
  );
endinterface

// File: rtl/regfile_param.sv
// ----------------------------------------------------------------------------
// regfile_param
// Parameterised register file with one write port (full-word or single-lane
// merge), two combinational read ports, a mem_data selector, a fixed target
// tap and a registered branch-condition evaluator.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset; clears registers, taken, taken_valid
//   bus   : regfile_param_if.slave (see interface header for signal roles)
// Every read path (rd_data0/1, mem_data, target, condition operands) sees the
// post-write value of a register being written in the same cycle.
// ----------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int NREGS   = 8,
  parameter int LANE_W  = 4,
  parameter int ADR_IDX = 4,
  parameter int NMEM    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_param_if.slave  bus
);
  localparam int NLANES     = DATA_W / LANE_W;
  localparam int LANE_IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;

  logic [DATA_W-1:0] regs     [NREGS];
  logic [DATA_W-1:0] reg_view [NREGS];  // register contents with write bypass
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic              wr_hit;
  logic [DATA_W-1:0] rd0_raw;
  logic [DATA_W-1:0] rd1_raw;
  logic [DATA_W-1:0] rd0_val;
  logic [DATA_W-1:0] rd1_val;
  logic [DATA_W-1:0] mem_val;
  logic              cond_known;
  logic              cond_result;
  logic              taken_reg;
  logic              taken_valid_reg;

  assign wr_hit = bus.wr_en && (int'(bus.wr_addr) < NREGS);

  // Current contents of the addressed register, the base for a lane merge.
  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wr_addr == 4'(i)) wr_old = regs[i];
    end
  end

  // Full-word writes replace everything; lane writes splice only the low
  // LANE_W bits of wr_data into the selected lane.
  always_comb begin
    wr_merged = bus.wr_data;
    if (bus.wr_lane_mode) begin
      wr_merged = wr_old;
      for (int l = 0; l < NLANES; l++) begin
        if (bus.wr_lane == LANE_IDX_W'(l))
          wr_merged[l*LANE_W +: LANE_W] = bus.wr_data[LANE_W-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_view
      assign reg_view[gi] = (wr_hit && (bus.wr_addr == 4'(gi))) ? wr_merged : regs[gi];
    end
  endgenerate

  // Out-of-range indices match no register and fall through to zero.
  always_comb begin
    rd0_raw = '0;
    rd1_raw = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.rd_addr0 == 4'(i)) rd0_raw = reg_view[i];
      if (bus.rd_addr1 == 4'(i)) rd1_raw = reg_view[i];
    end
  end

  always_comb begin
    mem_val = '0;
    for (int i = 0; i < NMEM && i < NREGS; i++) begin
      if (bus.mem_sel == 2'(i)) mem_val = reg_view[i];
    end
  end

  assign rd0_val = bus.imm ? DATA_W'(bus.rd_addr0) : rd0_raw;
  assign rd1_val = (bus.imm || bus.move) ? '0 : rd1_raw;

  assign bus.rd_data0 = rd0_val;
  assign bus.rd_data1 = rd1_val;
  assign bus.mem_data = mem_val;
  assign bus.target   = reg_view[ADR_IDX];

  // Condition evaluation uses the final read-port values, so bypass and
  // immediate/move overrides are already applied.
  always_comb begin
    cond_known  = 1'b1;
    cond_result = 1'b0;
    case (bus.cond_op)
      4'd4:    cond_result = (rd0_val >= rd1_val);
      4'd5:    cond_result = rd0_val[DATA_W-1];
      4'd6:    cond_result = (rd0_val == '0);
      4'd7:    cond_result = (rd0_val == rd1_val);
      4'd8:    cond_result = (rd0_val != rd1_val);
      default: cond_known  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.wr_addr == 4'(i)) regs[i] <= wr_merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_reg       <= 1'b0;
      taken_valid_reg <= 1'b0;
    end else begin
      taken_valid_reg <= bus.cond_valid && cond_known;
      if (bus.cond_valid && cond_known) taken_reg <= cond_result;
    end
  end

  assign bus.taken       = taken_reg;
  assign bus.taken_valid = taken_valid_reg;
endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] model [8];

  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(16), .LANE_W(4)) bus ();

  regfile_param #(
    .DATA_W(16), .NREGS(8), .LANE_W(4), .ADR_IDX(4), .NMEM(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 16'h0;
    bus.wr_lane_mode = 1'b0; bus.wr_lane = 2'd0;
    bus.imm = 1'b0; bus.move = 1'b0; bus.mem_sel = 2'd0;
    bus.cond_valid = 1'b0; bus.cond_op = 4'd0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_lane_mode = 1'b0;
    tick();
    bus.wr_en = 1'b0;
    if (a < 8) model[a[2:0]] = d;
    $display("write reg%0d = %h", a, d);
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %b exp 0", bus.taken); end
    n_vec++; if (bus.taken_valid !== 1'b0) begin n_err++; $display("FAIL reset_taken_valid got %b exp 0", bus.taken_valid); end
    n_vec++; if (bus.target !== 16'h0) begin n_err++; $display("FAIL reset_target got %h exp 0000", bus.target); end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr0 = 4'(i);
      #1;
      n_vec++;
      if (bus.rd_data0 !== 16'h0) begin n_err++; $display("FAIL reset_reg%0d got %h exp 0000", i, bus.rd_data0); end
      model[i] = 16'h0;
    end
    $display("reset checked");
  endtask

  task automatic test_full_write();
    bus.rd_addr0 = 4'd2; bus.rd_addr1 = 4'd2; bus.mem_sel = 2'd2;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 16'hBEEF; bus.wr_lane_mode = 1'b0;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'hBEEF) begin n_err++; $display("FAIL bypass_rd0 got %h exp beef", bus.rd_data0); end
    n_vec++; if (bus.mem_data !== 16'hBEEF) begin n_err++; $display("FAIL bypass_mem got %h exp beef", bus.mem_data); end
    tick();
    bus.wr_en = 1'b0; model[2] = 16'hBEEF;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'hBEEF) begin n_err++; $display("FAIL full_rd0 got %h exp beef", bus.rd_data0); end
    n_vec++; if (bus.rd_data1 !== 16'hBEEF) begin n_err++; $display("FAIL full_rd1 got %h exp beef", bus.rd_data1); end
    $display("full write reg2 = beef");
  endtask

  task automatic test_lane_write();
    do_write(4'd1, 16'h1234);
    bus.rd_addr0 = 4'd1;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd1; bus.wr_lane_mode = 1'b1;
    bus.wr_lane = 2'd2; bus.wr_data = 16'h000A;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'h1A34) begin n_err++; $display("FAIL lane2_bypass got %h exp 1a34", bus.rd_data0); end
    tick();
    bus.wr_en = 1'b0;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'h1A34) begin n_err++; $display("FAIL lane2 got %h exp 1a34", bus.rd_data0); end
    bus.wr_en = 1'b1; bus.wr_lane = 2'd3; bus.wr_data = 16'h00FF;
    tick();
    bus.wr_en = 1'b0; bus.wr_lane_mode = 1'b0;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'hFA34) begin n_err++; $display("FAIL lane3 got %h exp fa34", bus.rd_data0); end
    model[1] = 16'hFA34;
    $display("lane writes reg1 -> fa34");
  endtask

  task automatic test_cond_eq();
    do_write(4'd0, 16'h0005);
    do_write(4'd1, 16'h0005);
    bus.rd_addr0 = 4'd0; bus.rd_addr1 = 4'd1;
    bus.cond_valid = 1'b1; bus.cond_op = 4'd7;
    tick();
    bus.cond_valid = 1'b0;
    n_vec++; if (bus.taken !== 1'b1) begin n_err++; $display("FAIL eq_taken got %b exp 1", bus.taken); end
    n_vec++; if (bus.taken_valid !== 1'b1) begin n_err++; $display("FAIL eq_valid got %b exp 1", bus.taken_valid); end
    tick();
    n_vec++; if (bus.taken_valid !== 1'b0) begin n_err++; $display("FAIL eq_valid_drop got %b exp 0", bus.taken_valid); end
    n_vec++; if (bus.taken !== 1'b1) begin n_err++; $display("FAIL eq_hold got %b exp 1", bus.taken); end
    bus.cond_valid = 1'b1; bus.cond_op = 4'd8;
    tick();
    bus.cond_valid = 1'b0;
    n_vec++; if (bus.taken !== 1'b0) begin n_err++; $display("FAIL ne_taken got %b exp 0", bus.taken); end
    $display("cond EQ/NE on 5,5");
  endtask

  task automatic test_imm_move();
    bus.imm = 1'b1; bus.rd_addr0 = 4'd9; bus.rd_addr1 = 4'd2;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'h0009) begin n_err++; $display("FAIL imm_rd0 got %h exp 0009", bus.rd_data0); end
    n_vec++; if (bus.rd_data1 !== 16'h0000) begin n_err++; $display("FAIL imm_rd1 got %h exp 0000", bus.rd_data1); end
    bus.imm = 1'b0; bus.move = 1'b1; bus.rd_addr0 = 4'd2;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'hBEEF) begin n_err++; $display("FAIL move_rd0 got %h exp beef", bus.rd_data0); end
    n_vec++; if (bus.rd_data1 !== 16'h0000) begin n_err++; $display("FAIL move_rd1 got %h exp 0000", bus.rd_data1); end
    bus.move = 1'b0;
    #1;
    n_vec++; if (bus.rd_data1 !== 16'hBEEF) begin n_err++; $display("FAIL plain_rd1 got %h exp beef", bus.rd_data1); end
    $display("imm/move overrides");
  endtask

  task automatic test_unsigned_cmp();
    do_write(4'd3, 16'h8000);
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 16'h7FFF;
    #1;
    n_vec++; if (bus.target !== 16'h7FFF) begin n_err++; $display("FAIL target_bypass got %h exp 7fff", bus.target); end
    tick();
    bus.wr_en = 1'b0; model[4] = 16'h7FFF;
    bus.rd_addr0 = 4'd3; bus.rd_addr1 = 4'd4; bus.cond_valid = 1'b1;
    bus.cond_op = 4'd4; tick();
    n_vec++; if (bus.taken !== 1'b1) begin n_err++; $display("FAIL gte_8000_7fff got %b exp 1", bus.taken); end
    bus.cond_op = 4'd6; tick();
    n_vec++; if (bus.taken !== 1'b0) begin n_err++; $display("FAIL ez_8000 got %b exp 0", bus.taken); end
    bus.cond_op = 4'd5; tick();
    n_vec++; if (bus.taken !== 1'b1) begin n_err++; $display("FAIL ltz_8000 got %b exp 1", bus.taken); end
    bus.rd_addr0 = 4'd4; bus.rd_addr1 = 4'd3;
    bus.cond_op = 4'd4; tick();
    n_vec++; if (bus.taken !== 1'b0) begin n_err++; $display("FAIL gte_7fff_8000 got %b exp 0", bus.taken); end
    bus.cond_op = 4'd5; tick();
    bus.cond_valid = 1'b0;
    n_vec++; if (bus.taken !== 1'b0) begin n_err++; $display("FAIL ltz_7fff got %b exp 0", bus.taken); end
    n_vec++; if (bus.target !== 16'h7FFF) begin n_err++; $display("FAIL target got %h exp 7fff", bus.target); end
    $display("unsigned GTE / LTZ / EZ");
  endtask

  task automatic test_back_to_back();
    bus.rd_addr0 = 4'd0; bus.rd_addr1 = 4'd1;
    bus.cond_valid = 1'b1; bus.cond_op = 4'd7;
    tick();
    bus.cond_op = 4'd8;
    n_vec++; if (bus.taken !== 1'b1 || bus.taken_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first got %b/%b exp 1/1", bus.taken, bus.taken_valid); end
    tick();
    bus.cond_valid = 1'b0;
    n_vec++; if (bus.taken !== 1'b0 || bus.taken_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second got %b/%b exp 0/1", bus.taken, bus.taken_valid); end
    tick();
    n_vec++; if (bus.taken_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b exp 0", bus.taken_valid); end
    $display("back-to-back EQ then NE");
  endtask

  task automatic test_bypass_cond();
    bus.rd_addr0 = 4'd0; bus.mem_sel = 2'd0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd0; bus.wr_data = 16'h0000;
    bus.cond_valid = 1'b1; bus.cond_op = 4'd6;
    #1;
    n_vec++; if (bus.mem_data !== 16'h0000) begin n_err++; $display("FAIL bypass_mem0 got %h exp 0000", bus.mem_data); end
    tick();
    bus.wr_en = 1'b0; bus.cond_valid = 1'b0; model[0] = 16'h0;
    n_vec++; if (bus.taken !== 1'b1) begin n_err++; $display("FAIL bypass_ez got %b exp 1", bus.taken); end
    $display("write+cond same cycle");
  endtask

  task automatic test_invalid_addr();
    bus.wr_en = 1'b1; bus.wr_addr = 4'd12; bus.wr_data = 16'h5555;
    bus.rd_addr0 = 4'd12; bus.cond_valid = 1'b1; bus.cond_op = 4'd3;
    #1;
    n_vec++; if (bus.rd_data0 !== 16'h0000) begin n_err++; $display("FAIL rd_idx12 got %h exp 0000", bus.rd_data0); end
    tick();
    bus.wr_en = 1'b0; bus.cond_valid = 1'b0;
    n_vec++; if (bus.taken !== 1'b1) begin n_err++; $display("FAIL op3_hold got %b exp 1", bus.taken); end
    n_vec++; if (bus.taken_valid !== 1'b0) begin n_err++; $display("FAIL op3_valid got %b exp 0", bus.taken_valid); end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr0 = 4'(i);
      #1;
      n_vec++;
      if (bus.rd_data0 !== model[i]) begin n_err++; $display("FAIL wr12_reg%0d got %h exp %h", i, bus.rd_data0, model[i]); end
    end
    $display("out-of-range write/read and unknown cond_op");
  endtask

  task automatic test_reset_priority();
    tick();
    rst_n = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 4'd4; bus.wr_data = 16'hFFFF;
    bus.cond_valid = 1'b1; bus.cond_op = 4'd7;
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.taken !== 1'b0) begin n_err++; $display("FAIL rstp_taken got %b exp 0", bus.taken); end
    n_vec++; if (bus.taken_valid !== 1'b0) begin n_err++; $display("FAIL rstp_valid got %b exp 0", bus.taken_valid); end
    n_vec++; if (bus.target !== 16'h0000) begin n_err++; $display("FAIL rstp_target got %h exp 0000", bus.target); end
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr0 = 4'(i);
      #1;
      n_vec++;
      if (bus.rd_data0 !== 16'h0) begin n_err++; $display("FAIL rstp_reg%0d got %h exp 0000", i, bus.rd_data0); end
    end
    $display("reset priority over write and cond");
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.rd_addr0 = 4'd0; bus.rd_addr1 = 4'd0;
    test_reset();
    test_full_write();
    test_lane_write();
    test_cond_eq();
    test_imm_move();
    test_unsigned_cmp();
    test_back_to_back();
    test_bypass_cond();
    test_invalid_addr();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 16: register and data-port width in bits.
REQ-002 Parameter NREGS, default 8: number of architectural registers, 2..16.
REQ-003 Parameter LANE_W, default 4: lane width for lane writes; DATA_W SHALL be a multiple of LANE_W.
REQ-004 Parameter ADR_IDX, default 4: index of the register driven on target.
REQ-005 Parameter NMEM, default 4: registers 0..NMEM-1 are selectable onto mem_data.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-008 wr_en  in  1  write enable.
REQ-009 wr_addr  in  4  write register index.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 wr_lane_mode  in  1  0 = full-word write, 1 = single-lane write.
REQ-012 wr_lane  in  clog2(DATA_W/LANE_W)  target lane when wr_lane_mode=1.
REQ-013 rd_addr0, rd_addr1  in  4 each  read indices.
REQ-014 rd_data0, rd_data1  out  DATA_W each  read data, combinational.
REQ-015 imm  in  1  immediate mode; move  in  1  move mode.
REQ-016 mem_sel  in  2  register select for mem_data; mem_data  out  DATA_W.
REQ-017 target  out  DATA_W  current value of register ADR_IDX.
REQ-018 cond_valid  in  1  branch-condition evaluation request; cond_op  in  4  condition code.
REQ-019 taken  out  1  registered branch result; taken_valid  out  1  one-cycle result strobe.

Function
REQ-020 Writes SHALL commit on the rising clk edge when rst_n=1, wr_en=1 and wr_addr<NREGS; wr_addr>=NREGS SHALL be ignored.
REQ-021 Full-word write (wr_lane_mode=0) SHALL replace all DATA_W bits.
REQ-022 Lane write SHALL place wr_data[LANE_W-1:0] into bits [wr_lane*LANE_W +: LANE_W] and leave all other bits unchanged.
REQ-023 Write-through bypass: when wr_en=1 and wr_addr equals a read index, that read port SHALL show the post-write (merged) value in the same cycle; same for mem_data and target.
REQ-024 Read index >=NREGS SHALL return 0.
REQ-025 rd_data0 SHALL be rd_addr0 zero-extended to DATA_W when imm=1.
REQ-026 rd_data1 SHALL be 0 when imm=1 or move=1.
REQ-027 mem_data SHALL be register mem_sel when mem_sel<NMEM, else 0 (bypass per REQ-023 applies).
REQ-028 Conditions on A=rd_data0, B=rd_data1 (post-bypass): 4 GTE unsigned A>=B; 5 LTZ A[DATA_W-1]=1; 6 EZ A==0; 7 EQ A==B; 8 NE A!=B.
REQ-029 With cond_valid=1 and a code from REQ-028, the next edge SHALL load taken with the result and set taken_valid=1 for exactly one cycle; latency 1 cycle.
REQ-030 With cond_valid=1 and any other code, taken SHALL hold and taken_valid SHALL be 0.
REQ-031 With cond_valid=0, taken SHALL hold its last value and taken_valid SHALL be 0.
REQ-032 Back-to-back cond_valid cycles SHALL each produce their own result on consecutive cycles.
REQ-033 A write and a condition in the same cycle SHALL evaluate on the bypassed value.
REQ-034 No combinational latches; all register and flag state SHALL be flip-flops.

Reset
REQ-035 rst_n=0 at a rising edge SHALL clear all registers, taken and taken_valid to 0.
REQ-036 Reset SHALL take priority over a simultaneous write or cond_valid; neither SHALL take effect.
REQ-037 Combinational outputs during reset SHALL reflect cleared state one edge after reset is sampled.

Verification
REQ-038 Reset, then write 0xBEEF to reg 2 full-word, read rd_addr0=2 -> 0xBEEF; same-cycle read during write -> 0xBEEF (bypass).
REQ-039 Reg 1=0x1234, lane write wr_data=0x000A, wr_lane=2 -> reg 1=0x1A34; lane 3 write 0xF -> 0xFA34.
REQ-040 reg0=5, reg1=5, cond_op=7 cond_valid=1 -> next cycle taken=1, taken_valid=1, then taken_valid=0, taken holds 1; cond_op=8 -> taken=0.
REQ-041 imm=1, rd_addr0=9 -> rd_data0=0x0009, rd_data1=0; cond_op=4 with A=0x8000, B=0x7FFF -> taken=1 (unsigned); cond_op=5 -> taken=1.
REQ-042 wr_addr=12 with NREGS=8 -> no register changes, read index 12 -> 0; cond_op=3 -> taken unchanged, taken_valid=0.
REQ-043 rst_n=0 with wr_en=1 and cond_valid=1 in the same cycle -> all registers 0, taken=0, taken_valid=0 next cycle; target=0.
